// File: rtl/types_pkg.sv
// Shared pipeline types: instruction word constants and the prefetch FIFO entry.
package types_pkg;

    localparam int          PKG_XLEN  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PKG_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with synchronous clear; DEPTH is a power of two.
module fetch_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output fetch_entry_t               head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Pointer and occupancy next-state; clear wins over push/pop.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) begin
                wr_d = wr_q + AW'(1'b1);
            end else begin
                wr_d = wr_q;
            end
            if (pop_i) begin
                rd_d = rd_q + AW'(1'b1);
            end else begin
                rd_d = rd_q;
            end
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage carries no reset; occupancy alone qualifies the head.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, pipelined imem port, prefetch FIFO and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_count / bubble_count performance counters.
module fetch_stage
    import types_pkg::*;
#(
    parameter int               XLEN     = PKG_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     bubble_count
`endif
);

    localparam int              FCW  = $clog2(DEPTH+1);
    localparam int              CW   = FCW + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(3'd4);

    logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d, inflight_s;
    logic [FCW-1:0]  fifo_cnt_s;
    fetch_entry_t    head_s, push_data_s;
    logic            req_s, grant_s, flush_s, keep_s, load_s, fifo_empty_s;
    logic            pop_s, bypass_s, push_s;

    // Issue and response steering.
    always_comb begin
        inflight_s   = out_q + CW'(fifo_cnt_s);
        req_s        = reset && !StallF && (inflight_s < CW'(DEPTH));
        grant_s      = req_s && imem_gnt;
        flush_s      = FlushD || PCSrcE;
        fifo_empty_s = (fifo_cnt_s == '0);
        keep_s       = imem_rvalid && (drop_q == '0) && !PCSrcE;
        load_s       = !StallD && !flush_s;
        pop_s        = load_s && !fifo_empty_s;
        bypass_s     = load_s && fifo_empty_s && keep_s;
        push_s       = keep_s && !bypass_s;
        push_data_s  = '{instr: imem_rdata, pc: rsp_pc_q};
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .clear_i     (PCSrcE),
        .count_o     (fifo_cnt_s),
        .head_o      (head_s)
    );

    // PC, response-PC and counters; a redirect turns everything still in flight into drops.
    always_comb begin
        out_d    = out_q + CW'(grant_s) - CW'(imem_rvalid);
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        if (PCSrcE) begin
            pc_d     = {PCTargetE[XLEN-1:2], 2'b00};
            rsp_pc_d = {PCTargetE[XLEN-1:2], 2'b00};
            drop_d   = out_d;
        end else begin
            if (grant_s) begin
                pc_d = pc_q + STEP;
            end else begin
                pc_d = pc_q;
            end
            if (imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
            if (keep_s) begin
                rsp_pc_d = rsp_pc_q + STEP;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
        end
    end

    // IF/ID next-state: flush > stall > FIFO head > bypass > bubble.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (flush_s) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!StallD) begin
            if (!fifo_empty_s) begin
                instr_d = head_s.instr;
                pcd_d   = head_s.pc;
                pcp4_d  = head_s.pc + STEP;
                valid_d = 1'b1;
            end else if (keep_s) begin
                instr_d = imem_rdata;
                pcd_d   = rsp_pc_q;
                pcp4_d  = rsp_pc_q + STEP;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            instr_q  <= NOP_INSTR;
            pcd_q    <= '0;
            pcp4_q   <= STEP;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    // Count real loads and non-flush bubbles into IF/ID.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (load_s && (!fifo_empty_s || keep_s)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (load_s && fifo_empty_s && !keep_s) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

    assign imem_req  = req_s;
    assign imem_addr = pc_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcp4_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order latency memory model plus an
// instruction-stream scoreboard (expected PCD sequence, instruction = f(PC)).
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
    logic        imem_req, imem_gnt, imem_rvalid, ValidD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, bubble_count;
`endif

    fetch_stage dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0, lat = 1, gnt_pct = 100, nvalid = 0, last_rdy = 0;
    logic [31:0] pend_addr[$];
    int          pend_rdy[$];
    logic [31:0] exp_pc = 32'h0, next_fetch = 32'h0;
    bit          load_edge = 1'b0;
    logic        obs_req, obs_rvalid;
    logic [31:0] obs_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive memory, observe at mid-cycle, update models, advance.
    task automatic step();
        int r;
        imem_rvalid = (pend_addr.size() > 0) && (pend_rdy[0] <= cyc);
        imem_rdata  = imem_rvalid ? memf(pend_addr[0]) : $urandom();
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        #4;
        obs_req = imem_req; obs_addr = imem_addr; obs_rvalid = imem_rvalid;
        if (!reset) begin
            pend_addr.delete(); pend_rdy.delete(); last_rdy = 0;
            exp_pc = 32'h0; next_fetch = 32'h0;
        end else begin
            if (imem_rvalid) begin
                void'(pend_addr.pop_front()); void'(pend_rdy.pop_front());
            end
            if (imem_req && imem_gnt) begin
                r = cyc + lat;
                if (r <= last_rdy) r = last_rdy + 1;
                pend_addr.push_back(imem_addr); pend_rdy.push_back(r); last_rdy = r;
                next_fetch = imem_addr + 32'd4;
            end
            if (PCSrcE) begin
                next_fetch = {PCTargetE[31:2], 2'b00};
                exp_pc     = {PCTargetE[31:2], 2'b00};
            end
        end
        load_edge = reset && !StallD;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        checks++; if (InstrD !== NOP) begin errors++; $display("FAIL rst_instr got %h want %h", InstrD, NOP); end
        checks++; if (PCD !== 32'h0) begin errors++; $display("FAIL rst_pcd got %h want 0", PCD); end
        checks++; if (PCPlus4D !== 32'h4) begin errors++; $display("FAIL rst_pcp4 got %h want 4", PCPlus4D); end
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ValidD); end
    endtask

    task automatic test_stream();
        lat = 1; gnt_pct = 100; reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) begin
                checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", obs_req, obs_addr); end
                checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", ValidD); end
            end
            if (i == 1) begin
                checks++; if (obs_addr !== 32'h4) begin errors++; $display("FAIL second_addr got %h want 4", obs_addr); end
                checks++; if (ValidD !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", ValidD); end
            end
            if (load_edge && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL stream pcd=%h instr=%h want pcd=%h instr=%h", PCD, InstrD, exp_pc, memf(exp_pc));
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
    endtask

    task automatic test_stall_d();
        int n0;
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (PCD !== exp_pc - 32'd4 || ValidD !== 1'b1) begin errors++; $display("FAIL stalld_hold pcd=%h valid=%b want %h/1", PCD, ValidD, exp_pc - 32'd4); end
            if (i == 3) begin
                checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL stalld_req got %b want 0", obs_req); end
            end
        end
        StallD = 1'b0; n0 = nvalid;
        for (int i = 0; i < 10; i++) begin
            step();
            if (load_edge && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc)) begin
                    errors++; $display("FAIL stalld_stream pcd=%h instr=%h want pcd=%h instr=%h", PCD, InstrD, exp_pc, memf(exp_pc));
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
        checks++; if (nvalid - n0 != 10) begin errors++; $display("FAIL stalld_count got %0d want 10", nvalid - n0); end
    endtask

    task automatic test_stall_f();
        logic [31:0] nf;
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL stallf_req got %b want 0", obs_req); end
            if (i >= 1) begin
                checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL stallf_bubble got %b want 0", ValidD); end
            end
            if (load_edge && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc)) begin
                    errors++; $display("FAIL stallf_stream pcd=%h instr=%h want pcd=%h", PCD, InstrD, exp_pc);
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
        StallF = 1'b0; nf = next_fetch;
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== nf) begin errors++; $display("FAIL stallf_resume req=%b addr=%h want 1/%h", obs_req, obs_addr, nf); end
        for (int i = 0; i < 6; i++) begin
            step();
            if (load_edge && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc)) begin
                    errors++; $display("FAIL stallf_after pcd=%h instr=%h want pcd=%h", PCD, InstrD, exp_pc);
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
    endtask

    task automatic test_redirect(input int latency, input logic [31:0] tgt, input string nm);
        bit found = 1'b0;
        lat = latency;
        for (int i = 0; i < 6; i++) begin
            step();
            if (load_edge && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc)) begin
                    errors++; $display("FAIL %s_pre pcd=%h instr=%h want pcd=%h", nm, PCD, InstrD, exp_pc);
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = tgt;
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        checks++; if (imem_addr !== {tgt[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr got %h want %h", nm, imem_addr, {tgt[31:2], 2'b00}); end
        checks++; if (InstrD !== NOP || ValidD !== 1'b0) begin errors++; $display("FAIL %s_flush instr=%h valid=%b want %h/0", nm, InstrD, ValidD, NOP); end
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (load_edge && ValidD === 1'b1) begin
                found = 1'b1;
                checks++;
                if (PCD !== {tgt[31:2], 2'b00} || InstrD !== memf({tgt[31:2], 2'b00})) begin
                    errors++; $display("FAIL %s_first pcd=%h instr=%h want pcd=%h", nm, PCD, InstrD, {tgt[31:2], 2'b00});
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL %s_timeout got no valid load want one within 30 cycles", nm); end
    endtask

    task automatic test_random();
        int n0 = nvalid;
        bit redir;
        gnt_pct = 70;
        for (int i = 0; i < 400; i++) begin
            lat    = $urandom_range(3, 1);
            StallF = ($urandom_range(99) < 15);
            StallD = ($urandom_range(99) < 25);
            redir  = (i == 5) || ($urandom_range(99) < 4);
            PCSrcE = redir; FlushD = redir;
            PCTargetE = (i == 5) ? 32'hFFFF_FFF9 : $urandom();
            step();
            if (load_edge && ValidD === 1'b1) begin
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
                    errors++; $display("FAIL random cyc=%0d pcd=%h instr=%h want pcd=%h instr=%h", cyc, PCD, InstrD, exp_pc, memf(exp_pc));
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
        StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; FlushD = 1'b0; gnt_pct = 100;
        checks++; if (nvalid - n0 <= 60) begin errors++; $display("FAIL random_progress got %0d loads want >60", nvalid - n0); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        lat = 3; StallD = 1'b1;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b0; StallD = 1'b0;
        step();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_port req=%b addr=%h want 0/0", imem_req, imem_addr); end
        checks++; if (InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h4 || ValidD !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ifid instr=%h pcd=%h pcp4=%h valid=%b want %h/0/4/0", InstrD, PCD, PCPlus4D, ValidD, NOP);
        end
        reset = 1'b1; lat = 1;
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin errors++; $display("FAIL mid_restart req=%b addr=%h want 1/0", obs_req, obs_addr); end
        for (int i = 0; i < 10; i++) begin
            step();
            if (load_edge && ValidD === 1'b1) begin
                found = 1'b1;
                checks++;
                if (PCD !== exp_pc || InstrD !== memf(exp_pc)) begin
                    errors++; $display("FAIL mid_stream pcd=%h instr=%h want pcd=%h", PCD, InstrD, exp_pc);
                end
                exp_pc += 32'd4; nvalid++;
            end
        end
        checks++; if (!found || exp_pc === 32'h0) begin errors++; $display("FAIL mid_progress got next_pc=%h want loads after restart", exp_pc); end
    endtask

    initial begin
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_stall_d();
        test_stall_f();
        test_redirect(3, 32'h0000_0103, "redir_lat3");
        test_redirect(1, 32'h0000_0200, "redir_rvalid");
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
